// File: rtl/div_unit_if.sv
// Operand/result bundle between the EX stage (master) and the divider (slave).
// Signal names follow the divider's point of view.
interface div_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;

    modport master (
        output signed_div_i,
        output opdata1_i,
        output opdata2_i,
        output start_i,
        output annul_i,
        input  result_o,
        input  ready_o
    );

    modport slave (
        input  signed_div_i,
        input  opdata1_i,
        input  opdata2_i,
        input  start_i,
        input  annul_i,
        output result_o,
        output ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Bit-serial restoring divider for DIV/DIVU; returns {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: skip the iteration when |dividend| < |divisor|.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst,
    div_unit_if.slave    bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     dividend_q, dividend_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     abs1, abs2;
    logic [WIDTH:0]       rem_sh, trial;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_step, quo_step, rem_fix, quo_fix;

    always_comb begin
        op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
        op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
        // The most negative value negates to itself, which is its correct magnitude.
        abs1    = op1_neg ? -bus.opdata1_i : bus.opdata1_i;
        abs2    = op2_neg ? -bus.opdata2_i : bus.opdata2_i;

        rem_sh   = {rem_q, dividend_q[WIDTH-1]};
        trial    = rem_sh - {1'b0, divisor_q};
        q_bit    = ~trial[WIDTH];
        rem_step = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step = {dividend_q[WIDTH-2:0], q_bit};
        rem_fix  = neg_rem_q ? -rem_step : rem_step;
        quo_fix  = neg_quo_q ? -quo_step : quo_step;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        rem_d      = rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        unique case (state_q)
            StFree: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (bus.start_i && !bus.annul_i) begin
                    // StByZero is the two-cycle short path; it reports {rem_q, 0}.
                    if (bus.opdata2_i == '0) begin
                        state_d = StByZero;
                        rem_d   = '0;
                    end
`ifdef DIV_EARLY_OUT_EN
                    else if (abs1 < abs2) begin
                        state_d = StByZero;
                        rem_d   = bus.opdata1_i;
                    end
`endif
                    else begin
                        state_d    = StOn;
                        dividend_d = abs1;
                        divisor_d  = abs2;
                        rem_d      = '0;
                        cnt_d      = '0;
                        neg_quo_d  = op1_neg ^ op2_neg;
                        neg_rem_d  = op1_neg;
                    end
                end
            end
            StByZero: begin
                state_d  = StEnd;
                result_d = {rem_q, {WIDTH{1'b0}}};
                ready_d  = 1'b1;
            end
            StOn: begin
                if (bus.annul_i) begin
                    state_d  = StFree;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else begin
                    rem_d      = rem_step;
                    dividend_d = quo_step;
                    cnt_d      = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d  = StEnd;
                        result_d = {rem_fix, quo_fix};
                        ready_d  = 1'b1;
                    end
                end
            end
            StEnd: begin
                if (!bus.start_i || bus.annul_i) begin
                    state_d  = StFree;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = StFree;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StFree;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rem_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rem_q      <= rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.ready_o  = ready_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus annul and async-reset sequences.
module tb_div_unit;
    localparam int unsigned W = 32;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    typedef struct {
        logic           sgn;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp;
        bit             early;  // |a| < |b| with b != 0
        string          name;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled by the following posedge (edge 1).
    task automatic do_div(input vec_t v);
        int n;
        int lat;
        lat = (v.b == '0) ? 2 : ((EarlyEn && v.early) ? 2 : W + 1);
        bus.signed_div_i = v.sgn;
        bus.opdata1_i    = v.a;
        bus.opdata2_i    = v.b;
        bus.start_i      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready_o && n < 40);
        chk({v.name, " latency"}, 64'(n), 64'(lat));
        chk({v.name, " result"}, bus.result_o, v.exp);
        @(negedge clk);
        chk({v.name, " hold ready"}, 64'(bus.ready_o), 64'd1);
        chk({v.name, " hold result"}, bus.result_o, v.exp);
        bus.start_i = 1'b0;
        @(negedge clk);
        chk({v.name, " release ready"}, 64'(bus.ready_o), 64'd0);
        chk({v.name, " release result"}, bus.result_o, 64'd0);
    endtask

    vec_t vecs[15];

    initial begin
        int n;
        int seen;
        vec_t v;

        checks   = 0;
        failures = 0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 1'b0, "u 100/7"};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 1'b0, "s -7/2"};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 1'b0, "s 7/-2"};
        vecs[3]  = '{1'b0, 32'h12345678,   32'd0,          64'h0,                 1'b0, "u div0"};
        vecs[4]  = '{1'b1, 32'h12345678,   32'd0,          64'h0,                 1'b0, "s div0"};
        vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 1'b0, "s min/-1"};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 1'b0, "u max/1"};
        vecs[7]  = '{1'b0, 32'd3,          32'd5,          64'h00000003_00000000, 1'b1, "u 3/5"};
        vecs[8]  = '{1'b1, 32'hFFFFFFFD,   32'd5,          64'hFFFFFFFD_00000000, 1'b1, "s -3/5"};
        vecs[9]  = '{1'b0, 32'd9,          32'd3,          64'h00000000_00000003, 1'b0, "u 9/3"};
        vecs[10] = '{1'b1, 32'h80000000,   32'd7,          64'hFFFFFFFE_EDB6DB6E, 1'b0, "s min/7"};
        vecs[11] = '{1'b0, 32'h80000000,   32'd7,          64'h00000002_12492492, 1'b0, "u 2^31/7"};
        vecs[12] = '{1'b1, 32'd100,        32'hFFFFFFF9,   64'h00000002_FFFFFFF2, 1'b0, "s 100/-7"};
        vecs[13] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 1'b0, "s -100/-7"};
        vecs[14] = '{1'b0, 32'hFFFFFFFF,   32'd10,         64'h00000005_19999999, 1'b0, "u max/10"};

        rst              = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset ready", 64'(bus.ready_o), 64'd0);
        chk("reset result", bus.result_o, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 15; i++) do_div(vecs[i]);

        // Annul at edge 10 of 1000/3; nothing may complete afterwards.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (9) @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        chk("annul ready", 64'(bus.ready_o), 64'd0);
        chk("annul result", bus.result_o, 64'd0);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.ready_o) seen++;
        end
        chk("annul no ready", 64'(seen), 64'd0);
        v = '{1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0, "post-annul 9/3"};
        do_div(v);

        // Async reset mid-cycle at edge 15 of an in-flight division.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd1000;
        bus.opdata2_i    = 32'd3;
        bus.start_i      = 1'b1;
        repeat (14) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mid reset ready", 64'(bus.ready_o), 64'd0);
        chk("mid reset result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("after reset ready", 64'(bus.ready_o), 64'd0);

        // Async reset while a result is being held in END.
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.ready_o && n < 40);
        chk("end hold result", bus.result_o, 64'h00000002_0000000E);
        rst = 1'b0;
        #1;
        chk("end reset ready", 64'(bus.ready_o), 64'd0);
        chk("end reset result", bus.result_o, 64'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        v = '{1'b0, 32'd3, 32'd5, 64'h00000003_00000000, 1'b1, "post-reset 3/5"};
        do_div(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider; responder to the EX stage for DIV/DIVU.
- EX issues operands with a start request. The unit runs a bit-serial restoring division and returns {remainder, quotient}.
- EX forwards remainder to HI and quotient to LO via its whilo_o/hi_o/lo_o path.
- EX holds the pipeline stall while start_i is high and ready_o is low.

Parameters:
- WIDTH, 32, operand width; result_o is 2*WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- signed_div_i  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  WIDTH  dividend; sampled with start.
- opdata2_i  input  WIDTH  divisor; sampled with start.
- start_i  input  1  division request; level, held high by EX until ready_o seen.
- annul_i  input  1  cancel in-flight division (flush/exception).
- result_o  output  2*WIDTH  {remainder[2W-1:W], quotient[W-1:0]}.
- ready_o  output  1  result_o valid.

Behaviour:
- Reset (rst=0, async):
  - state=FREE, result_o=0, ready_o=0, iteration counter=0, internal dividend/divisor/partial-remainder registers=0.
- States: FREE, BYZERO, ON, END. All outputs are registered.
- FREE:
  - start_i=1, annul_i=0, opdata2_i==0 -> BYZERO.
  - start_i=1, annul_i=0, opdata2_i!=0 -> ON.
    - Latch |op1|, |op2| (two's-complement negate when signed and the MSB is set), plus the sign flags.
    - Clear partial remainder and counter.
  - Otherwise stay; ready_o=0, result_o=0.
- BYZERO: next edge -> END with result_o=0.
- ON:
  - One restoring step per cycle:
    - shift {rem, dividend} left 1;
    - trial = rem - divisor (WIDTH+1 bits);
    - if trial is non-negative, rem=trial and quotient bit=1, else quotient bit=0.
  - Counter increments each step. After WIDTH steps -> END.
  - On the END transition, apply signs:
    - quotient negated iff signed and the operand signs differ;
    - remainder negated iff signed and the dividend is negative.
  - Load result_o and set ready_o=1.
  - annul_i=1 in any ON cycle -> FREE immediately; ready_o stays 0, result_o=0. Annul has priority over a completing step.
- END:
  - ready_o=1 and result_o held stable while start_i=1.
  - start_i=0 -> FREE next edge; ready_o=0, result_o=0.
  - annul_i in END is treated as start_i=0.
- Latency: start sampled at edge 0; ready_o high after edge WIDTH+1 (33 edges at default). Divide-by-zero: ready_o after edge 2.
- A new start is accepted only from FREE. Back-to-back divisions therefore need start_i low for at least one cycle.
- Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000 (wraps), remainder=0. No exception.
- |dividend| and |divisor| use WIDTH-bit unsigned magnitudes, so 0x80000000 stays 0x80000000.
- Reset asserted mid-operation aborts immediately to the reset state. No partial result is visible.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in FREE, when the divisor is nonzero and |op1| < |op2| (unsigned magnitude compare):
  - go directly to END;
  - quotient=0, remainder=op1 (original signed value);
  - ready_o after edge 2.
- Not defined: all nonzero-divisor cases take the full WIDTH+1 latency.
- Results are identical either way; only latency differs.

Test Plan:
- Unsigned 100/7, start held -> ready_o rises after edge 33; result_o = {0x00000002, 0x0000000E}; drop start -> ready_o=0, result_o=0 next edge.
- Signed 0xFFFFFFF9(-7)/2 -> result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Signed 7/0xFFFFFFFE(-2) -> {0x00000001, 0xFFFFFFFD}.
- Divisor 0 (either signedness), dividend 0x12345678 -> ready_o after edge 2, result_o=0.
- Start 1000/3, pulse annul_i at edge 10 -> state FREE, ready_o never asserts. Then 9/3 with start -> {0, 3} after 33 edges.
- Signed 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- rst=0 at edge 15 of a division (async, mid-cycle) -> ready_o=0, result_o=0 immediately. After release, 3/5 completes: {3, 0} after 33 edges, or after 2 edges with DIV_EARLY_OUT_EN.
